prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868; clock cycles per UART bit (100 MHz / 115200 baud); legal range 8 or greater.
REQ-002 SHALL have parameter MAX_WORDS, default 4096; largest program length accepted, in 32-bit words.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset, asynchronous and active-high.
REQ-005 SHALL have port rx, input, 1 bit; UART serial input (8N1, idle high), asynchronous to clk.
REQ-006 SHALL have port mem_we, output, 4 bits; byte write enables to the BRAM instruction/data port.
REQ-007 SHALL have port mem_addr, output, 32 bits; BRAM byte address, always word-aligned.
REQ-008 SHALL have port mem_din, output, 32 bits; BRAM write data.
REQ-009 SHALL have port core_rst_n, output, 1 bit; active-low reset to the pipelined core, held low until the load completes.
REQ-010 SHALL have port done, output, 1 bit; load completed successfully (sticky).
REQ-011 SHALL have port error, output, 1 bit; load aborted (sticky).

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-013 SHALL run a UART receiver with states RX_IDLE, RX_START, RX_DATA, RX_STOP.
REQ-014 RX_IDLE: a synchronized rx of 0 SHALL move to RX_START and clear the bit timer.
REQ-015 RX_START: at timer = CLKS_PER_BIT/2 (integer division) SHALL resample; 0 moves to RX_DATA, 1 is a glitch and returns to RX_IDLE with no byte and no error.
REQ-016 RX_DATA: SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, then move to RX_STOP.
REQ-017 RX_STOP: SHALL sample after CLKS_PER_BIT cycles; 1 gives a one-cycle byte_valid with the byte; 0 is a framing error.
REQ-018 The receiver SHALL return to RX_IDLE in the cycle after the stop sample.
REQ-019 SHALL run a loader FSM with states L_LEN, L_DATA, L_DONE, L_ERR.
REQ-020 L_LEN: SHALL collect 4 bytes little-endian into len_words (32 bits).
  - On the 4th byte, len_words = 0 goes to L_DONE.
  - len_words > MAX_WORDS goes to L_ERR.
  - Any other value goes to L_DATA with word_idx = 0.
REQ-021 L_DATA: SHALL assemble 4 bytes little-endian; byte k of the stream fills bits [8k+7:8k].
REQ-022 In the cycle after the 4th byte_valid of a word, SHALL drive the write for exactly one cycle:
  - mem_we = 4'hF
  - mem_addr = word_idx*4
  - mem_din = the assembled word
REQ-023 After each write SHALL increment word_idx; when word_idx reaches len_words SHALL go to L_DONE, otherwise collect the next word.
REQ-024 Outside a write cycle SHALL hold mem_we = 0; mem_addr and mem_din hold their last values.
REQ-025 L_DONE: SHALL set done = 1 and core_rst_n = 1, ignore all further rx traffic, and never leave except by rst.
REQ-026 A framing error in L_LEN or L_DATA SHALL go to L_ERR.
REQ-027 L_ERR: SHALL set error = 1, hold core_rst_n = 0 and mem_we = 0, and never leave except by rst.
REQ-028 done and error SHALL never both be 1.
REQ-029 core_rst_n SHALL change only on the clk edge that enters L_DONE, so it is glitch-free and synchronous to clk.
REQ-030 The word counter SHALL be 32 bits with no wrap-around; the MAX_WORDS check bounds it.
REQ-031 The last write address SHALL be (len_words-1)*4.

Reset
REQ-032 While rst = 1 the block SHALL hold:
  - all FSMs in RX_IDLE / L_LEN, with all counters and byte assembly cleared
  - mem_we = 0, mem_addr = 0, mem_din = 0
  - core_rst_n = 0, done = 0, error = 0
REQ-033 Asserting rst mid-byte or mid-word SHALL discard the partial byte or word; words already written stay in BRAM.
REQ-034 After rst the next frame SHALL start again at the length field.

Verification (CLKS_PER_BIT = 16, MAX_WORDS = 8)
REQ-035 Send length 2, then words 0x00000013 and 0xDEADBEEF.
  - Required: exactly two writes, (addr 0x0, din 0x00000013, we F) then (addr 0x4, din 0xDEADBEEF, we F).
  - Required: done = 1 and core_rst_n = 1 one cycle after the second write.
REQ-036 Send length 0.
  - Required: no writes; done = 1 after the 4th length byte.
REQ-037 Send length 9.
  - Required: error = 1, core_rst_n = 0, no writes, and further bytes ignored.
REQ-038 Send length 1, then the 2nd data byte with stop bit 0.
  - Required: error = 1, mem_we never asserted.
REQ-039 Drive a 4-cycle low pulse on rx while idle.
  - Required: no byte, no error, and a following valid frame loads correctly.
REQ-040 Assert rst after 2 of 4 bytes of word 1, then resend a full frame of length 1 with word 0x12345678.
  - Required: one write, addr 0x0, din 0x12345678, then done = 1.

Source files
------------

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader. Receives a program image over a UART line and
// writes it word by word into the core's instruction/data BRAM. The core is
// held in reset until the whole image has been written.
//
// Stream format (8N1 bytes, everything little-endian):
//   4 bytes  : program length in 32-bit words
//   4*N bytes: program words, word 0 first
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 8)
//   MAX_WORDS    : largest accepted program length in words
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset
//   rx         : UART serial input, idle high, asynchronous to clk
//   mem_we     : byte write enables to the BRAM (4'hF during a write cycle)
//   mem_addr   : BRAM byte address, word-aligned
//   mem_din    : BRAM write data
//   core_rst_n : active-low core reset, released when the load completes
//   done       : load completed (sticky until rst)
//   error      : load aborted by framing error or bad length (sticky until rst)
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        core_rst_n,
    output logic        done,
    output logic        error
);

    localparam int            TW        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_BIT  = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [31:0]   MAX_LEN   = 32'(MAX_WORDS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR}        ld_state_t;

    // -------------------------------------------------------------------------
    // Input synchronizer (idles high so reset does not look like a start bit)
    // -------------------------------------------------------------------------
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;

    always_comb begin
        rx_meta_d = rx;
        rx_sync_d = rx_meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
        end
    end

    // -------------------------------------------------------------------------
    // UART receiver
    // -------------------------------------------------------------------------
    rx_state_t     rx_state_q, rx_state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        timer_d      = timer_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    timer_d    = '0;
                end
            end
            RX_START: begin
                // Re-check the line in the middle of the start bit; a high
                // level here means the falling edge was only a glitch.
                if (timer_q == HALF_BIT) begin
                    timer_d    = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RX_DATA: begin
                if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};   // LSB arrives first
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RX_STOP: begin
                if (timer_q == LAST_TICK) begin
                    byte_valid_d = rx_sync_q;
                    frame_err_d  = !rx_sync_q;
                    rx_state_d   = RX_IDLE;
                    timer_d      = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Loader
    // -------------------------------------------------------------------------
    ld_state_t   ld_state_q, ld_state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] asm_merged;
    logic [31:0] len_q, len_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_din_q, mem_din_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        core_rst_n_q, core_rst_n_d;

    // The assembly word with the current received byte dropped into its lane.
    always_comb begin
        asm_merged = asm_q;
        asm_merged[{byte_cnt_q, 3'b000} +: 8] = shift_q;
    end

    always_comb begin
        ld_state_d = ld_state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        mem_we_d   = 4'h0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (ld_state_q)
            L_LEN: begin
                if (frame_err_q) begin
                    ld_state_d = L_ERR;
                end else if (byte_valid_q) begin
                    asm_d      = asm_merged;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        len_d      = asm_merged;
                        word_idx_d = '0;
                        if (asm_merged == 32'd0) begin
                            ld_state_d = L_DONE;
                        end else if (asm_merged > MAX_LEN) begin
                            ld_state_d = L_ERR;
                        end else begin
                            ld_state_d = L_DATA;
                        end
                    end
                end
            end
            L_DATA: begin
                if (frame_err_q) begin
                    ld_state_d = L_ERR;
                end else begin
                    // Advance the word index during the write cycle so that
                    // done rises on the cycle right after the final write.
                    if (mem_we_q != 4'h0) begin
                        word_idx_d = word_idx_q + 32'd1;
                        if (word_idx_d == len_q) begin
                            ld_state_d = L_DONE;
                        end
                    end
                    if (byte_valid_q) begin
                        asm_d      = asm_merged;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            mem_we_d   = 4'hF;
                            mem_addr_d = word_idx_q << 2;
                            mem_din_d  = asm_merged;
                        end
                    end
                end
            end
            L_DONE: ld_state_d = L_DONE;
            L_ERR:  ld_state_d = L_ERR;
            default: ld_state_d = L_ERR;
        endcase

        // Status outputs are registered copies of the next state, so they
        // change exactly on the edge that enters the terminal state.
        done_d       = (ld_state_d == L_DONE);
        error_d      = (ld_state_d == L_ERR);
        core_rst_n_d = (ld_state_d == L_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_state_q   <= L_LEN;
            byte_cnt_q   <= '0;
            asm_q        <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            mem_we_q     <= 4'h0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            ld_state_q   <= ld_state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_q        <= asm_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            done_q       <= done_d;
            error_q      <= error_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign done       = done_q;
    assign error      = error_q;
    assign core_rst_n = core_rst_n_q;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Drives UART frames into prog_loader. For each frame a reference model,
// working directly on the byte list, predicts the BRAM writes and the final
// done/error status; predicted writes go into a queue that an independent
// monitor pops whenever the DUT asserts mem_we.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int CPB  = 16;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        core_rst_n;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    wr_t        exp_q[$];
    wr_t        exp_e;
    logic [7:0] tx_bytes[$];
    bit         tx_stop[$];
    int         n_exp_wr;
    int         n_obs_wr;
    int         cyc;
    int         last_wr_cyc;
    int         done_rise_cyc;
    bit         both_seen;
    logic       done_prev;
    bit         exp_done;
    bit         exp_err;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (done && error) both_seen = 1'b1;
            if (done && !done_prev) done_rise_cyc = cyc;
            done_prev = done;
            if (mem_we !== 4'h0) begin
                n_obs_wr++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got we=%h addr=%h din=%h, required no write",
                             mem_we, mem_addr, mem_din);
                end else begin
                    exp_e = exp_q.pop_front();
                    check32("wr_we", 32'(mem_we), 32'hF);
                    check32("wr_addr", mem_addr, exp_e.addr);
                    check32("wr_din", mem_din, exp_e.din);
                    check32("wr_core_rst_n", 32'(core_rst_n), 32'd0);
                end
                last_wr_cyc = cyc;
            end
        end
    end

    // -------------------------------------------------------- reference model
    // Walks the byte list: length field first, then whole words, stopping at
    // the first bad stop bit or at a terminal outcome.
    function automatic void run_model();
        logic [31:0] len;
        logic [31:0] w;
        int          n;
        int          p;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        n_exp_wr = 0;
        exp_q.delete();
        n   = tx_bytes.size();
        len = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= n) return;
            if (!tx_stop[i]) begin
                exp_err = 1'b1;
                return;
            end
            len |= 32'(tx_bytes[i]) << (8 * i);
        end
        if (len == 0) begin
            exp_done = 1'b1;
            return;
        end
        if (len > MAXW) begin
            exp_err = 1'b1;
            return;
        end
        for (int wi = 0; wi < int'(len); wi++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                p = 4 + 4 * wi + k;
                if (p >= n) return;
                if (!tx_stop[p]) begin
                    exp_err = 1'b1;
                    return;
                end
                w |= 32'(tx_bytes[p]) << (8 * k);
            end
            exp_q.push_back('{addr: 32'(wi * 4), din: w});
            n_exp_wr++;
        end
        exp_done = 1'b1;
    endfunction

    // -------------------------------------------------------------- stimulus
    task automatic push_byte(input logic [7:0] b, input bit stop);
        tx_bytes.push_back(b);
        tx_stop.push_back(stop);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) push_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic clear_frame();
        tx_bytes.delete();
        tx_stop.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_mem_we", 32'(mem_we), 32'd0);
        check32("rst_mem_addr", mem_addr, 32'd0);
        check32("rst_mem_din", mem_din, 32'd0);
        check32("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        check32("rst_done", 32'(done), 32'd0);
        check32("rst_error", 32'(error), 32'd0);
        exp_q.delete();
        n_obs_wr      = 0;
        cyc           = 0;
        last_wr_cyc   = -1;
        done_rise_cyc = -1;
        both_seen     = 1'b0;
        done_prev     = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input string name, input bit glitch);
        do_reset();
        run_model();
        if (glitch) begin
            rx = 1'b0;
            repeat (4) @(posedge clk);
            #1 rx = 1'b1;
            repeat (3 * CPB) @(posedge clk);
            #1;
            check32({name, "_glitch_error"}, 32'(error), 32'd0);
            check32({name, "_glitch_write"}, 32'(n_obs_wr), 32'd0);
        end
        for (int i = 0; i < tx_bytes.size(); i++) send_byte(tx_bytes[i], tx_stop[i]);
        repeat (4 * CPB) @(posedge clk);
        #1;
        check32({name, "_done"}, 32'(done), 32'(exp_done));
        check32({name, "_error"}, 32'(error), 32'(exp_err));
        check32({name, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
        check32({name, "_write_count"}, 32'(n_obs_wr), 32'(n_exp_wr));
        check32({name, "_done_and_error"}, 32'(both_seen), 32'd0);
        if (exp_done && n_exp_wr > 0)
            check32({name, "_done_latency"}, 32'(done_rise_cyc - last_wr_cyc), 32'd1);
        $display("[TB] %s: bytes=%0d writes=%0d/%0d done=%0b error=%0b core_rst_n=%0b",
                 name, tx_bytes.size(), n_obs_wr, n_exp_wr, done, error, core_rst_n);
    endtask

    initial begin
        int          len;
        int          bad_pos;
        string       nm;

        // Two-word program
        clear_frame();
        push_word(32'd2); push_word(32'h0000_0013); push_word(32'hDEAD_BEEF);
        run_frame("len2", 1'b0);

        // Empty program; trailing traffic must be ignored
        clear_frame();
        push_word(32'd0); push_byte(8'hA5, 1'b1);
        run_frame("len0", 1'b0);

        // Over-long program
        clear_frame();
        push_word(32'd9); push_word(32'h1122_3344);
        run_frame("len9", 1'b0);

        // Framing error on the second data byte
        clear_frame();
        push_word(32'd1); push_byte(8'h11, 1'b1); push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b1); push_byte(8'h44, 1'b1);
        run_frame("stop_err", 1'b0);

        // Start-bit glitch, then a valid frame
        clear_frame();
        push_word(32'd1); push_word($urandom);
        run_frame("glitch", 1'b1);

        // Reset halfway through word 1, then a fresh frame
        clear_frame();
        push_word(32'd2); push_word($urandom); push_byte(8'h78, 1'b1); push_byte(8'h56, 1'b1);
        run_frame("partial", 1'b0);
        clear_frame();
        push_word(32'd1); push_word(32'h1234_5678);
        run_frame("after_rst", 1'b0);

        // Randomized frames
        for (int t = 0; t < 8; t++) begin
            clear_frame();
            len = int'($urandom_range(0, 10));
            push_word(32'(len));
            for (int w = 0; w < len && w < MAXW; w++) push_word($urandom);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) push_byte(8'($urandom), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                bad_pos = int'($urandom_range(0, tx_bytes.size() - 1));
                tx_stop[bad_pos] = 1'b0;
            end
            nm = $sformatf("rand%0d", t);
            run_frame(nm, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

endmodule
